// File: rtl/asteroid_manager.sv
// asteroid_manager: asteroid entity table with timed spawning from a rotating
// spawn table, per-tick movement with screen wrap-around, and delete requests
// from collision logic.
module asteroid_manager #(
  parameter int ASTEROID_COUNT = 8,
  parameter int COORD_W        = 10,
  parameter int SCREEN_W       = 320,
  parameter int SCREEN_H       = 240,
  parameter int SPAWN_COUNT    = 4,
  // Entry 0 occupies the least significant bits; entry = {y, x, slope[5:0]}.
  parameter logic [SPAWN_COUNT*(2*COORD_W+6)-1:0] SPAWN_TABLE = {
    {10'd50,  10'd0,   6'b000001},
    {10'd50,  10'd220, 6'b000101},
    {10'd120, 10'd50,  6'b101000},
    {10'd0,   10'd50,  6'b111000}},
  parameter int SPAWN_INTERVAL = 64,
  localparam int ENTITY_SIZE   = 2*COORD_W+14,
  localparam int AW            = (ASTEROID_COUNT > 1) ? $clog2(ASTEROID_COUNT) : 1,
  localparam int CW            = $clog2(ASTEROID_COUNT+1)
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 i_tick,
  input  logic                                 i_spawn_en,
  input  logic [2:0]                           i_sprite_sel,
  input  logic                                 i_delete_valid,
  input  logic [AW-1:0]                        i_delete_addr,
  output logic [ASTEROID_COUNT*ENTITY_SIZE-1:0] o_asteroids_data,
  output logic [CW-1:0]                        o_active_count,
  output logic                                 o_table_full,
  output logic                                 o_spawn_pulse,
  output logic [AW-1:0]                        o_spawn_slot
);

  localparam int TE   = 2*COORD_W+6;
  localparam int TW   = $clog2(SPAWN_INTERVAL+1);
  localparam int IW   = (SPAWN_COUNT > 1) ? $clog2(SPAWN_COUNT) : 1;
  // Bit positions inside one entity word.
  localparam int XS_B = 0;
  localparam int XD_B = 2;
  localparam int YS_B = 3;
  localparam int YD_B = 5;
  localparam int X_B  = 6;
  localparam int Y_B  = 6 + COORD_W;
  localparam int XQ_B = 6 + 2*COORD_W;
  localparam int YQ_B = 8 + 2*COORD_W;
  localparam int V_B  = 13 + 2*COORD_W;
  localparam logic [COORD_W-1:0] X_MAX = COORD_W'(SCREEN_W-1);
  localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(SCREEN_H-1);

  typedef enum logic [1:0] {S_WAIT, S_PENDING, S_SPAWN} state_t;

  state_t                 r_state;
  logic [TW-1:0]          r_timer;
  logic [IW-1:0]          r_idx;
  logic [ENTITY_SIZE-1:0] r_ent [ASTEROID_COUNT];
  logic [CW-1:0]          r_count;
  logic                   r_full;
  logic                   r_pulse;
  logic [AW-1:0]          r_slot;

  logic [ENTITY_SIZE-1:0] w_ent_nxt [ASTEROID_COUNT];
  logic [CW-1:0]          w_count_nxt;
  logic                   w_free_found;
  logic [AW-1:0]          w_free_slot;
  logic                   w_do_spawn;
  logic [TE-1:0]          w_tbl_entry;
  logic [ENTITY_SIZE-1:0] w_spawn_ent;

  // One-pixel step with wrap: max+1 -> 0 and 0-1 -> max.
  function automatic logic [COORD_W-1:0] step_coord(input logic [COORD_W-1:0] c,
                                                    input logic dec,
                                                    input logic [COORD_W-1:0] cmax);
    if (dec) return (c == '0) ? cmax : c - COORD_W'(1);
    else     return (c == cmax) ? '0 : c + COORD_W'(1);
  endfunction

  // Movement of one live entity on a tick: reload quotas when both are spent,
  // otherwise spend x quota first, then y quota.
  function automatic logic [ENTITY_SIZE-1:0] move_ent(input logic [ENTITY_SIZE-1:0] e);
    logic [ENTITY_SIZE-1:0] n;
    n = e;
    if (e[XQ_B +: 2] == 2'd0 && e[YQ_B +: 2] == 2'd0) begin
      n[XQ_B +: 2] = e[XS_B +: 2];
      n[YQ_B +: 2] = e[YS_B +: 2];
    end else if (e[XQ_B +: 2] != 2'd0) begin
      n[X_B +: COORD_W] = step_coord(e[X_B +: COORD_W], e[XD_B], X_MAX);
      n[XQ_B +: 2]      = e[XQ_B +: 2] - 2'd1;
    end else begin
      n[Y_B +: COORD_W] = step_coord(e[Y_B +: COORD_W], e[YD_B], Y_MAX);
      n[YQ_B +: 2]      = e[YQ_B +: 2] - 2'd1;
    end
    return n;
  endfunction

  assign w_tbl_entry = SPAWN_TABLE[32'(r_idx)*TE +: TE];
  assign w_spawn_ent = {1'b1, i_sprite_sel, 2'b00, 2'b00, w_tbl_entry};
  assign w_do_spawn  = (r_state == S_PENDING) && i_spawn_en && w_free_found;

  // Lowest-index free slot, judged on registered valid bits only.
  always_comb begin
    w_free_found = 1'b0;
    w_free_slot  = '0;
    for (int i = ASTEROID_COUNT-1; i >= 0; i--) begin
      if (!r_ent[i][V_B]) begin
        w_free_found = 1'b1;
        w_free_slot  = AW'(i);
      end
    end
  end

  // Next table contents: delete beats spawn beats move; also count live slots.
  always_comb begin
    w_count_nxt = '0;
    for (int i = 0; i < ASTEROID_COUNT; i++) begin
      w_ent_nxt[i] = r_ent[i];
      if (i_delete_valid && i_delete_addr == AW'(i) && r_ent[i][V_B])
        w_ent_nxt[i] = '0;
      else if (w_do_spawn && w_free_slot == AW'(i))
        w_ent_nxt[i] = w_spawn_ent;
      else if (i_tick && r_ent[i][V_B])
        w_ent_nxt[i] = move_ent(r_ent[i]);
      w_count_nxt = w_count_nxt + CW'(w_ent_nxt[i][V_B]);
    end
  end

  // Entity table and occupancy registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < ASTEROID_COUNT; i++) r_ent[i] <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
    end else begin
      for (int i = 0; i < ASTEROID_COUNT; i++) r_ent[i] <= w_ent_nxt[i];
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CW'(ASTEROID_COUNT));
    end
  end

  // Spawn FSM: count ticks down, then hold a pending spawn until a slot frees up.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_WAIT;
      r_timer <= TW'(SPAWN_INTERVAL);
      r_idx   <= '0;
      r_pulse <= 1'b0;
      r_slot  <= '0;
    end else begin
      r_pulse <= 1'b0;
      case (r_state)
        S_WAIT: begin
          if (r_timer == '0) begin
            r_state <= S_PENDING;
          end else if (i_tick) begin
            r_timer <= r_timer - TW'(1);
            if (r_timer == TW'(1)) r_state <= S_PENDING;
          end
        end
        S_PENDING: begin
          if (w_do_spawn) begin
            r_state <= S_SPAWN;
            r_pulse <= 1'b1;
            r_slot  <= w_free_slot;
            r_timer <= TW'(SPAWN_INTERVAL);
            r_idx   <= (r_idx == IW'(SPAWN_COUNT-1)) ? '0 : r_idx + IW'(1);
          end
        end
        S_SPAWN: r_state <= S_WAIT;
        default: r_state <= S_WAIT;
      endcase
    end
  end

  for (genvar g = 0; g < ASTEROID_COUNT; g++) begin : g_out
    assign o_asteroids_data[g*ENTITY_SIZE +: ENTITY_SIZE] = r_ent[g];
  end

  assign o_active_count = r_count;
  assign o_table_full   = r_full;
  assign o_spawn_pulse  = r_pulse;
  assign o_spawn_slot   = r_slot;

endmodule

// File: tb/tb_asteroid_manager.sv
// Testbench for asteroid_manager: table-driven spawn vectors through a scoreboard
// queue, plus hand-written sequences for full-table hold, delete, reset and wrap.
module tb_asteroid_manager;

  localparam int ES = 34;
  localparam int N  = 8;
  localparam logic [103:0] TBL1 = {10'd50, 10'd0, 6'b000001, 10'd50, 10'd220, 6'b000101,
                                   10'd120, 10'd50, 6'b101000, 10'd0, 10'd50, 6'b111000};
  localparam logic [103:0] TBL2 = {10'd0, 10'd0, 6'b101000, 10'd239, 10'd0, 6'b001000,
                                   10'd0, 10'd0, 6'b000101, 10'd0, 10'd319, 6'b000001};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst1_n, tick1, en1, dv1;
  logic [2:0]      sel1, da1;
  logic [N*ES-1:0] data1;
  logic [3:0]      cnt1;
  logic            full1, pulse1;
  logic [2:0]      slot1;

  logic            rst2_n, tick2, en2, dv2;
  logic [2:0]      sel2, da2;
  logic [N*ES-1:0] data2;
  logic [3:0]      cnt2;
  logic            full2, pulse2;
  logic [2:0]      slot2;

  asteroid_manager #(.ASTEROID_COUNT(8), .COORD_W(10), .SCREEN_W(320), .SCREEN_H(240),
                     .SPAWN_COUNT(4), .SPAWN_TABLE(TBL1), .SPAWN_INTERVAL(4)) u_dut (
    .clk(clk), .reset_n(rst1_n), .i_tick(tick1), .i_spawn_en(en1), .i_sprite_sel(sel1),
    .i_delete_valid(dv1), .i_delete_addr(da1), .o_asteroids_data(data1),
    .o_active_count(cnt1), .o_table_full(full1), .o_spawn_pulse(pulse1),
    .o_spawn_slot(slot1));

  asteroid_manager #(.ASTEROID_COUNT(8), .COORD_W(10), .SCREEN_W(320), .SCREEN_H(240),
                     .SPAWN_COUNT(4), .SPAWN_TABLE(TBL2), .SPAWN_INTERVAL(1)) u_wrap (
    .clk(clk), .reset_n(rst2_n), .i_tick(tick2), .i_spawn_en(en2), .i_sprite_sel(sel2),
    .i_delete_valid(dv2), .i_delete_addr(da2), .o_asteroids_data(data2),
    .o_active_count(cnt2), .o_table_full(full2), .o_spawn_pulse(pulse2),
    .o_spawn_slot(slot2));

  typedef struct {
    logic          tick;
    logic [2:0]    sel;
    logic          exp_pulse;
    logic [2:0]    exp_slot;
    logic [3:0]    exp_count;
    logic          exp_full;
    logic          chk_ent;
    logic [ES-1:0] exp_ent;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [ES-1:0] ent(input logic v, input logic [2:0] spr,
                                        input logic [1:0] yq, input logic [1:0] xq,
                                        input logic [9:0] y, input logic [9:0] x,
                                        input logic [5:0] s);
    return {v, spr, yq, xq, y, x, s};
  endfunction

  // Independent copy of the spawn table contents, indexed by table entry.
  function automatic logic [25:0] tbl1(input int k);
    case (k % 4)
      0:       return {10'd0,   10'd50,  6'b111000};
      1:       return {10'd120, 10'd50,  6'b101000};
      2:       return {10'd50,  10'd220, 6'b000101};
      default: return {10'd50,  10'd0,   6'b000001};
    endcase
  endfunction

  function automatic logic [ES-1:0] s1(input int i);
    return data1[i*ES +: ES];
  endfunction

  function automatic logic [ES-1:0] s2(input int i);
    return data2[i*ES +: ES];
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive1(input logic t, input logic e, input logic [2:0] s,
                        input logic d, input logic [2:0] a);
    tick1 = t; en1 = e; sel1 = s; dv1 = d; da1 = a;
  endtask

  task automatic drive2(input logic t, input logic e);
    tick2 = t; en2 = e;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    vec_t cur;
    // Fill eight spawn rounds: 4 ticks, pending cycle (write), spawn cycle.
    for (int k = 0; k < 8; k++) begin
      for (int t = 0; t < 6; t++) begin
        v.tick      = (t < 4);
        v.sel       = 3'(k + 1);
        v.exp_pulse = (t == 4);
        v.exp_slot  = (t < 4) ? ((k == 0) ? 3'd0 : 3'(k - 1)) : 3'(k);
        v.exp_count = (t < 4) ? 4'(k) : 4'(k + 1);
        v.exp_full  = (t >= 4) && (k == 7);
        v.chk_ent   = (t == 4);
        v.exp_ent   = {1'b1, 3'(k + 1), 2'b00, 2'b00, tbl1(k)};
        vecs.push_back(v);
      end
    end

    rst1_n = 1'b0; rst2_n = 1'b0;
    drive1(1'b0, 1'b1, 3'd0, 1'b0, 3'd0);
    sel2 = 3'd1; dv2 = 1'b0; da2 = 3'd0;
    drive2(1'b0, 1'b0);
    cyc(); cyc();
    chk("rst_data", 64'(data1 != '0), 64'd0);
    chk("rst_count", 64'(cnt1), 64'd0);
    chk("rst_full", 64'(full1), 64'd0);
    chk("rst_pulse", 64'(pulse1), 64'd0);
    chk("rst_slot", 64'(slot1), 64'd0);
    rst1_n = 1'b1; rst2_n = 1'b1;

    // Table-driven spawn rounds through the scoreboard.
    foreach (vecs[n]) begin
      drive1(vecs[n].tick, 1'b1, vecs[n].sel, 1'b0, 3'd0);
      sb.push_back(vecs[n]);
      cyc();
      cur = sb.pop_front();
      chk($sformatf("v%0d_pulse", n), 64'(pulse1), 64'(cur.exp_pulse));
      chk($sformatf("v%0d_slot", n), 64'(slot1), 64'(cur.exp_slot));
      chk($sformatf("v%0d_count", n), 64'(cnt1), 64'(cur.exp_count));
      chk($sformatf("v%0d_full", n), 64'(full1), 64'(cur.exp_full));
      if (cur.chk_ent)
        chk($sformatf("v%0d_ent", n), 64'(s1(int'(cur.exp_slot))), 64'(cur.exp_ent));
    end

    // Full table: timer expires, spawn must be held rather than lost.
    for (int t = 0; t < 4; t++) begin
      drive1(1'b1, 1'b1, 3'd6, 1'b0, 3'd0);
      cyc();
    end
    for (int t = 0; t < 3; t++) begin
      drive1(1'b0, 1'b1, 3'd6, 1'b0, 3'd0);
      cyc();
      chk("full_hold_pulse", 64'(pulse1), 64'd0);
      chk("full_hold_count", 64'(cnt1), 64'd8);
    end
    drive1(1'b0, 1'b1, 3'd6, 1'b1, 3'd2);
    cyc();
    chk("del2_ent", 64'(s1(2)), 64'd0);
    chk("del2_count", 64'(cnt1), 64'd7);
    chk("del2_full", 64'(full1), 64'd0);
    chk("del2_pulse", 64'(pulse1), 64'd0);
    drive1(1'b0, 1'b1, 3'd6, 1'b0, 3'd0);
    cyc();
    chk("refill_pulse", 64'(pulse1), 64'd1);
    chk("refill_slot", 64'(slot1), 64'd2);
    chk("refill_count", 64'(cnt1), 64'd8);
    chk("refill_full", 64'(full1), 64'd1);
    chk("refill_ent", 64'(s1(2)), 64'(ent(1'b1, 3'd6, 2'd0, 2'd0, 10'd0, 10'd50, 6'b111000)));
    cyc();
    chk("refill_pulse_drop", 64'(pulse1), 64'd0);

    // Delete and tick on the same slot in the same cycle; then delete an empty slot.
    drive1(1'b1, 1'b1, 3'd6, 1'b1, 3'd5);
    cyc();
    chk("deltick_ent", 64'(s1(5)), 64'd0);
    chk("deltick_count", 64'(cnt1), 64'd7);
    drive1(1'b0, 1'b1, 3'd6, 1'b1, 3'd5);
    cyc();
    chk("delempty_count", 64'(cnt1), 64'd7);
    chk("delempty_ent", 64'(s1(5)), 64'd0);

    // Down to 5 live slots, park in PENDING with spawning disabled, then reset.
    drive1(1'b0, 1'b0, 3'd6, 1'b1, 3'd6);
    cyc();
    drive1(1'b0, 1'b0, 3'd6, 1'b1, 3'd7);
    cyc();
    chk("five_live", 64'(cnt1), 64'd5);
    for (int t = 0; t < 3; t++) begin
      drive1(1'b1, 1'b0, 3'd6, 1'b0, 3'd0);
      cyc();
    end
    for (int t = 0; t < 2; t++) begin
      drive1(1'b0, 1'b0, 3'd6, 1'b0, 3'd0);
      cyc();
      chk("pend_disabled_pulse", 64'(pulse1), 64'd0);
    end
    rst1_n = 1'b0;
    cyc();
    chk("midrst_data", 64'(data1 != '0), 64'd0);
    chk("midrst_count", 64'(cnt1), 64'd0);
    chk("midrst_full", 64'(full1), 64'd0);
    chk("midrst_pulse", 64'(pulse1), 64'd0);
    chk("midrst_slot", 64'(slot1), 64'd0);
    rst1_n = 1'b1;
    for (int t = 0; t < 4; t++) begin
      drive1(1'b1, 1'b1, 3'd7, 1'b0, 3'd0);
      cyc();
      chk("postrst_tick_pulse", 64'(pulse1), 64'd0);
    end
    drive1(1'b0, 1'b1, 3'd7, 1'b0, 3'd0);
    cyc();
    chk("postrst_pulse", 64'(pulse1), 64'd1);
    chk("postrst_slot", 64'(slot1), 64'd0);
    chk("postrst_ent", 64'(s1(0)), 64'(ent(1'b1, 3'd7, 2'd0, 2'd0, 10'd0, 10'd50, 6'b111000)));
    drive1(1'b0, 1'b0, 3'd0, 1'b0, 3'd0);

    // Screen wrap on the second instance: x 319 -> 0 and x 0 -> 319.
    drive2(1'b1, 1'b0); cyc();
    drive2(1'b0, 1'b1); cyc();
    chk("w_spawn0_pulse", 64'(pulse2), 64'd1);
    chk("w_spawn0_ent", 64'(s2(0)), 64'(ent(1'b1, 3'd1, 2'd0, 2'd0, 10'd0, 10'd319, 6'b000001)));
    drive2(1'b0, 1'b0); cyc();
    drive2(1'b1, 1'b0); cyc();
    chk("w_reload0", 64'(s2(0)), 64'(ent(1'b1, 3'd1, 2'd0, 2'd1, 10'd0, 10'd319, 6'b000001)));
    drive2(1'b1, 1'b0); cyc();
    chk("w_xinc_wrap", 64'(s2(0)), 64'(ent(1'b1, 3'd1, 2'd0, 2'd0, 10'd0, 10'd0, 6'b000001)));
    drive2(1'b0, 1'b1); cyc();
    chk("w_spawn1_slot", 64'(slot2), 64'd1);
    chk("w_spawn1_ent", 64'(s2(1)), 64'(ent(1'b1, 3'd1, 2'd0, 2'd0, 10'd0, 10'd0, 6'b000101)));
    drive2(1'b0, 1'b0); cyc();
    drive2(1'b1, 1'b0); cyc();
    chk("w_reload1", 64'(s2(1)), 64'(ent(1'b1, 3'd1, 2'd0, 2'd1, 10'd0, 10'd0, 6'b000101)));
    drive2(1'b1, 1'b0); cyc();
    chk("w_xdec_wrap", 64'(s2(1)), 64'(ent(1'b1, 3'd1, 2'd0, 2'd0, 10'd0, 10'd319, 6'b000101)));
    chk("w_slot0_move", 64'(s2(0)), 64'(ent(1'b1, 3'd1, 2'd0, 2'd0, 10'd0, 10'd1, 6'b000001)));
    chk("w_count", 64'(cnt2), 64'd2);
    drive2(1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
